// File: rtl/fifo_pkg.sv
// Shared helpers and defaults for the FIFO family: sizing functions and
// the wrap-around pointer increment used by both read and write pointers.
package fifo_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_LENGTH = 4;

  // Width needed to hold an occupancy value in 0..len.
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic int ptr_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  // Explicit modulo so non-power-of-two depths wrap at len-1, not at 2^n-1.
  function automatic int unsigned ptr_next(input int unsigned p, input int unsigned len);
    return (p == len - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_thresh_if.sv
// Push/pop bus of the threshold FIFO; the producer/consumer side is the
// master, the FIFO itself is the slave.
interface fifo_thresh_if
  import fifo_pkg::*;
#(
  parameter int width  = DEF_WIDTH,
  parameter int length = DEF_LENGTH
);
  localparam int CW = cnt_w(length);

  logic             push;
  logic             pop;
  logic [width-1:0] data;
  logic             clr_err;
  logic [width-1:0] out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, data, clr_err,
    input  out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, data, clr_err,
    output out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-around pointer register covering 0..length-1, advanced by inc.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int length = DEF_LENGTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      inc,
  output logic [ptr_w(length)-1:0]  ptr
);
  localparam int PW = ptr_w(length);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = PW'(ptr_next(32'(ptr_q), length));
  end

  always_ff @(posedge clk) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_thresh.sv
// Single-clock FWFT FIFO of arbitrary depth with occupancy count,
// almost-full/empty thresholds and sticky overflow/underflow flags.
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int width    = DEF_WIDTH,
  parameter int length   = DEF_LENGTH,
  parameter int af_level = 3,
  parameter int ae_level = 1
) (
  input  logic          clk,
  input  logic          rstn,
  fifo_thresh_if.slave  bus
);
  localparam int CW = cnt_w(length);
  localparam int PW = ptr_w(length);

  if (length < 2) begin : g_bad_length
    $fatal(1, "fifo_thresh: length must be >= 2");
  end
  if (af_level < 1 || af_level > length) begin : g_bad_af
    $fatal(1, "fifo_thresh: af_level must be in 1..length");
  end
  if (ae_level < 0 || ae_level >= length) begin : g_bad_ae
    $fatal(1, "fifo_thresh: ae_level must be in 0..length-1");
  end

  logic [width-1:0] mem [length];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty, full;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(length));

  // Push at full is only accepted when a pop frees the head slot in the same
  // edge; pop at empty is always refused, so push+pop on empty is push only.
  assign do_pop  = bus.pop && !empty;
  assign do_push = bus.push && (!full || bus.pop);

  fifo_ptr #(.length(length)) u_rd_ptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (do_pop),
    .ptr  (rd_ptr)
  );

  fifo_ptr #(.length(length)) u_wr_ptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (do_push),
    .ptr  (wr_ptr)
  );

  always_ff @(posedge clk) begin
    if (rstn && do_push) mem[wr_ptr] <= bus.data;
  end

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (bus.push && full && !bus.pop) ovf_d = 1'b1;
    if (bus.pop && empty)             unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.out          = empty ? '0 : mem[rd_ptr];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(af_level));
  assign bus.almost_empty = (count_q <= CW'(ae_level));
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_thresh.sv
// Directed bench for fifo_thresh: default 4-deep instance plus a 5-deep
// instance with af_level=5 / ae_level=0 driven from an op table.
module tb_fifo_thresh;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fifo_thresh_if #(.width(4), .length(4)) bus_a ();
  fifo_thresh_if #(.width(4), .length(5)) bus_b ();

  fifo_thresh #(.width(4), .length(4), .af_level(3), .ae_level(1)) u_dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_a.slave)
  );

  fifo_thresh #(.width(4), .length(5), .af_level(5), .ae_level(0)) u_dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_b.slave)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_pop [4] = '{2, 3, 4, 9};
  int ops [21]    = '{1,1,1,1,1, 2,2,2, 1,1,1, 3, 2,2,2,2,2, 1,3,3, 2};
  int q [$];

  initial begin
    int next_d;
    rstn = 1'b0;
    bus_a.push = 1'b1; bus_a.pop = 1'b0; bus_a.data = 4'd3; bus_a.clr_err = 1'b0;
    bus_b.push = 1'b0; bus_b.pop = 1'b0; bus_b.data = 4'd0; bus_b.clr_err = 1'b0;

    // 1: reset with push held
    step(); step();
    rstn = 1'b1;
    bus_a.push = 1'b0;
    chk("rst_empty", int'(bus_a.empty), 1);
    chk("rst_count", int'(bus_a.count), 0);
    chk("rst_ae", int'(bus_a.almost_empty), 1);
    chk("rst_af", int'(bus_a.almost_full), 0);
    chk("rst_full", int'(bus_a.full), 0);
    chk("rst_out", int'(bus_a.out), 0);
    chk("rst_ovf", int'(bus_a.overflow), 0);
    chk("rst_unf", int'(bus_a.underflow), 0);
    chk("rst_b_empty", int'(bus_b.empty), 1);

    // 2: fill 1..4
    for (int i = 1; i <= 4; i++) begin
      bus_a.push = 1'b1;
      bus_a.data = 4'(i);
      step();
      chk("fill_count", int'(bus_a.count), i);
      chk("fill_out", int'(bus_a.out), 1);
      chk("fill_ae", int'(bus_a.almost_empty), (i <= 1) ? 1 : 0);
      chk("fill_af", int'(bus_a.almost_full), (i >= 3) ? 1 : 0);
      chk("fill_full", int'(bus_a.full), (i == 4) ? 1 : 0);
    end

    // 3: overflow while full, then clear
    bus_a.data = 4'd5;
    step();
    bus_a.push = 1'b0;
    chk("ovf_count", int'(bus_a.count), 4);
    chk("ovf_set", int'(bus_a.overflow), 1);
    chk("ovf_out", int'(bus_a.out), 1);
    step();
    chk("ovf_sticky", int'(bus_a.overflow), 1);
    bus_a.clr_err = 1'b1;
    step();
    bus_a.clr_err = 1'b0;
    chk("ovf_clr", int'(bus_a.overflow), 0);

    // 4: push+pop at full, then drain across the wrap
    bus_a.push = 1'b1; bus_a.pop = 1'b1; bus_a.data = 4'd9;
    step();
    bus_a.push = 1'b0; bus_a.pop = 1'b0;
    chk("pp_full_count", int'(bus_a.count), 4);
    chk("pp_full_out", int'(bus_a.out), 2);
    chk("pp_full_ovf", int'(bus_a.overflow), 0);
    for (int k = 0; k < 4; k++) begin
      chk("drain_out", int'(bus_a.out), exp_pop[k]);
      bus_a.pop = 1'b1;
      step();
      chk("drain_count", int'(bus_a.count), 3 - k);
    end
    bus_a.pop = 1'b0;
    chk("drain_empty", int'(bus_a.empty), 1);
    chk("drain_out0", int'(bus_a.out), 0);
    chk("drain_unf", int'(bus_a.underflow), 0);

    // 5: push+pop at empty, then clr_err racing a fresh underflow
    bus_a.push = 1'b1; bus_a.pop = 1'b1; bus_a.data = 4'd7;
    step();
    bus_a.push = 1'b0;
    chk("pp_empty_count", int'(bus_a.count), 1);
    chk("pp_empty_out", int'(bus_a.out), 7);
    chk("pp_empty_unf", int'(bus_a.underflow), 1);
    step();
    chk("pop_last_count", int'(bus_a.count), 0);
    bus_a.clr_err = 1'b1;
    step();
    chk("unf_set_wins", int'(bus_a.underflow), 1);
    chk("unf_count", int'(bus_a.count), 0);
    bus_a.pop = 1'b0;
    step();
    bus_a.clr_err = 1'b0;
    chk("unf_clr", int'(bus_a.underflow), 0);

    // 6: depth-5 instance, 12 pushes interleaved with pops
    next_d = 1;
    for (int c = 0; c < 21; c++) begin
      bus_b.push = ops[c][0];
      bus_b.pop  = ops[c][1];
      bus_b.data = 4'(next_d);
      if (ops[c][1]) chk("b_pop_out", int'(bus_b.out), q[0]);
      step();
      if (ops[c][1]) void'(q.pop_front());
      if (ops[c][0]) begin
        q.push_back(next_d);
        next_d++;
      end
      chk("b_count", int'(bus_b.count), q.size());
      chk("b_full", int'(bus_b.full), (q.size() == 5) ? 1 : 0);
      chk("b_empty", int'(bus_b.empty), (q.size() == 0) ? 1 : 0);
      chk("b_af_eq_full", int'(bus_b.almost_full), int'(bus_b.full));
      chk("b_ae_eq_empty", int'(bus_b.almost_empty), int'(bus_b.empty));
    end
    bus_b.push = 1'b0; bus_b.pop = 1'b0;
    chk("b_pushes", next_d - 1, 12);
    chk("b_ovf", int'(bus_b.overflow), 0);
    chk("b_unf", int'(bus_b.underflow), 0);

    // Reset mid-operation discards contents
    bus_b.push = 1'b1; bus_b.data = 4'd6;
    step(); step();
    bus_b.push = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("b_midrst_count", int'(bus_b.count), 0);
    chk("b_midrst_out", int'(bus_b.out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
